// File: rtl/hit_mem_pkg.sv
// Shared definitions for the hit-map memory (HNM) scheduler: controller
// states, default geometry and derived widths.
package hit_mem_pkg;

  localparam int ROW_BITS_DEF = 7;
  localparam int COL_BITS_DEF = 4;
  localparam int ROW_W_DEF    = 1 << COL_BITS_DEF;
  localparam int ROWS_DEF     = 1 << ROW_BITS_DEF;
  localparam int COUNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    CLEAR,
    READ,
    READ_TAIL
  } hnm_state_e;

endpackage

// File: rtl/hit_memory_scheduler_rmw.sv
// hnm_rmw_pipe: read-modify-write stage for hit storage. An accepted hit
// reads its row on RAM port B; one cycle later the row is written back on
// port A with the hit's column bit set. A write to the same row in the
// directly preceding cycle is not yet visible in the RAM read data, so that
// write's data is forwarded instead.
module hnm_rmw_pipe
  import hit_mem_pkg::*;
#(
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int COL_BITS = COL_BITS_DEF
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       store_valid,
  input  logic [ROW_BITS-1:0]        store_row,
  input  logic [COL_BITS-1:0]        store_col,
  input  logic [(1<<COL_BITS)-1:0]   read_data,
  output logic                       write_valid,
  output logic [ROW_BITS-1:0]        write_row,
  output logic [(1<<COL_BITS)-1:0]   write_data
);

  localparam int ROW_W = 1 << COL_BITS;

  logic                vld_p1;
  logic [ROW_BITS-1:0] row_p1;
  logic [COL_BITS-1:0] col_p1;
  logic                vld_p2;
  logic [ROW_BITS-1:0] row_p2;
  logic [ROW_W-1:0]    data_p2;
  logic [ROW_W-1:0]    base;

  // Stage p1: hit accepted last cycle, its row data arrives from the RAM now.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      vld_p1 <= 1'b0;
      row_p1 <= '0;
      col_p1 <= '0;
    end else begin
      vld_p1 <= store_valid;
      row_p1 <= store_row;
      col_p1 <= store_col;
    end
  end

  // Merge the column bit into the freshest copy of the row.
  always_comb begin
    base = read_data;
    if (vld_p2 && (row_p2 == row_p1)) base = data_p2;
    write_valid = vld_p1;
    write_row   = vld_p1 ? row_p1 : '0;
    write_data  = vld_p1 ? (base | (ROW_W'(1) << col_p1)) : '0;
  end

  // Stage p2: remember the write just performed for forwarding.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      vld_p2  <= 1'b0;
      row_p2  <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      row_p2  <= row_p1;
      data_p2 <= write_data;
    end
  end

endmodule

// File: rtl/hit_memory_scheduler.sv
// hit_memory_scheduler: accepts hit addresses and sets the matching bit of
// the hit-map memory (HNM) through an external dual-port RAM, and schedules
// whole-memory clear and readout passes between stores.
// Build option: HNM_READ_SKIP_EMPTY_EN -- when defined, readout only flags
// rows holding a non-zero value; readDone still marks the final row.
module hit_memory_scheduler
  import hit_mem_pkg::*;
#(
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int COL_BITS = COL_BITS_DEF
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          clearReq,
  input  logic                          readReq,
  input  logic                          addrValid,
  input  logic [ROW_BITS+COL_BITS-1:0]  address,
  output logic                          addrReady,
  output logic                          busy,
  output logic                          clearDone,
  output logic                          readDone,
  output logic                          readRowValid,
  output logic [ROW_BITS-1:0]           readRowIndex,
  output logic [(1<<COL_BITS)-1:0]      readRowData,
  output logic [COUNT_W-1:0]            storedCount,
  output logic [ROW_BITS-1:0]           ramAddrA,
  output logic [(1<<COL_BITS)-1:0]      ramDinA,
  output logic                          ramWeA,
  output logic [ROW_BITS-1:0]           ramAddrB,
  output logic [(1<<COL_BITS)-1:0]      ramDinB,
  output logic                          ramWeB,
  input  logic [(1<<COL_BITS)-1:0]      ramDoutB
);

  localparam int ROW_W = 1 << COL_BITS;
  localparam int ROWS  = 1 << ROW_BITS;
  localparam logic [ROW_BITS-1:0] LAST_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0] LAST_PAIR = ROW_BITS'(ROWS / 2 - 1);

  hnm_state_e          state, state_next;
  logic                clear_pend, read_pend;
  logic                start_clear, start_read;
  logic                clear_last, read_issue;
  logic [ROW_BITS-1:0] row_cnt;
  logic                accept;
  logic [ROW_BITS-1:0] hit_row;
  logic [COL_BITS-1:0] hit_col;
  logic                wr_valid;
  logic [ROW_BITS-1:0] wr_row;
  logic [ROW_W-1:0]    wr_data;
  logic                rd_vld_p1;
  logic [ROW_BITS-1:0] rd_idx_p1;
  logic [COUNT_W-1:0]  stored_cnt;

  assign hit_row   = address[ROW_BITS+COL_BITS-1:COL_BITS];
  assign hit_col   = address[COL_BITS-1:0];
  assign addrReady = resetN && (state == IDLE) && !clear_pend && !read_pend
                     && !clearReq && !readReq;
  assign accept    = addrValid && addrReady;

  hnm_rmw_pipe #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_rmw (
    .clock       (clock),
    .resetN      (resetN),
    .store_valid (accept),
    .store_row   (hit_row),
    .store_col   (hit_col),
    .read_data   (ramDoutB),
    .write_valid (wr_valid),
    .write_row   (wr_row),
    .write_data  (wr_data)
  );

  // Next-state selection and RAM port steering for the current state.
  always_comb begin
    state_next  = state;
    start_clear = 1'b0;
    start_read  = 1'b0;
    clear_last  = 1'b0;
    read_issue  = 1'b0;
    ramAddrA    = '0;
    ramDinA     = '0;
    ramWeA      = 1'b0;
    ramAddrB    = '0;
    ramDinB     = '0;
    ramWeB      = 1'b0;
    case (state)
      IDLE, DRAIN: begin
        if (wr_valid) begin
          ramWeA   = 1'b1;
          ramAddrA = wr_row;
          ramDinA  = wr_data;
        end
        if (accept) ramAddrB = hit_row;
        if (state == IDLE) begin
          if (clear_pend || read_pend || clearReq || readReq) state_next = DRAIN;
        end else if (!wr_valid) begin
          if (clear_pend || clearReq) begin
            state_next  = CLEAR;
            start_clear = 1'b1;
          end else if (read_pend || readReq) begin
            state_next = READ;
            start_read = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      CLEAR: begin
        ramWeA     = 1'b1;
        ramWeB     = 1'b1;
        ramAddrA   = {row_cnt[ROW_BITS-2:0], 1'b0};
        ramAddrB   = {row_cnt[ROW_BITS-2:0], 1'b1};
        clear_last = (row_cnt == LAST_PAIR);
        if (clear_last) state_next = IDLE;
      end
      READ: begin
        ramAddrB   = row_cnt;
        read_issue = 1'b1;
        if (row_cnt == LAST_ROW) state_next = READ_TAIL;
      end
      READ_TAIL: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Controller state, sticky request flags and the clear/read row counter.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      clear_pend <= 1'b0;
      read_pend  <= 1'b0;
      row_cnt    <= '0;
    end else begin
      state      <= state_next;
      clear_pend <= start_clear ? 1'b0 : (clear_pend | clearReq);
      read_pend  <= start_read  ? 1'b0 : (read_pend  | readReq);
      if (start_clear || start_read) row_cnt <= '0;
      else if (state == CLEAR || state == READ) row_cnt <= row_cnt + 1'b1;
    end
  end

  // Readout stage p1: the row issued last cycle is now on ramDoutB.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_vld_p1 <= 1'b0;
      rd_idx_p1 <= '0;
    end else begin
      rd_vld_p1 <= read_issue;
      if (read_issue) rd_idx_p1 <= row_cnt;
    end
  end

  // Count accepted hits since the last completed clear, saturating.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stored_cnt <= '0;
    end else if (clear_last) begin
      stored_cnt <= '0;
    end else if (accept && (stored_cnt != {COUNT_W{1'b1}})) begin
      stored_cnt <= stored_cnt + 1'b1;
    end
  end

  assign busy         = (state != IDLE);
  assign clearDone    = clear_last;
  assign readDone     = (state == READ_TAIL);
  assign readRowIndex = rd_idx_p1;
  assign readRowData  = rd_vld_p1 ? ramDoutB : '0;
  assign storedCount  = stored_cnt;
`ifdef HNM_READ_SKIP_EMPTY_EN
  assign readRowValid = rd_vld_p1 && (ramDoutB != '0);
`else
  assign readRowValid = rd_vld_p1;
`endif

endmodule
